// File: rtl/shape_processor_apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// shape_processor_apb_bridge_pkg
// Shared types and constants for the APB front-end of shape_processor.
//   bridge_state_e  : bridge FSM state encoding
//   WAIT_CNT_WIDTH  : width of the wait-state down-counter (0..15 wait states)
//   CTRL_SFR_ADDR   : default byte address of the CTRL SFR
// -----------------------------------------------------------------------------
package shape_processor_apb_bridge_pkg;

    localparam int WAIT_CNT_WIDTH = 4;

    localparam logic [7:0] CTRL_SFR_ADDR = 8'h00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        WAIT    = 3'd3,
        RESP    = 3'd4
    } bridge_state_e;

endpackage

// File: rtl/shape_processor_apb_bridge_if.sv
// -----------------------------------------------------------------------------
// shape_processor_apb_bridge_if
// APB3 bus bundle between an APB master and the shape_processor bridge.
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   prdata, pready, pslverr              : slave  -> master
// -----------------------------------------------------------------------------
interface shape_processor_apb_bridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/shape_processor_apb_bridge_props.sv
// -----------------------------------------------------------------------------
// shape_processor_apb_bridge_props
// Protocol properties bound into shape_processor_apb_bridge.
//   clk, rst_n   : bridge clock and reset
//   state        : bridge FSM state
//   hit          : latched address decode of the current transfer
//   write, read  : processor strobes
//   pready       : APB ready
// -----------------------------------------------------------------------------
module shape_processor_apb_bridge_props
    import shape_processor_apb_bridge_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    input bridge_state_e state,
    input logic          hit,
    input logic          write,
    input logic          read,
    input logic          pready
);

    // Strobes seen since the bridge last sat in IDLE.
    logic [1:0] r_strobes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobes <= 2'd0;
        end else if (state == IDLE) begin
            r_strobes <= 2'd0;
        end else if ((write || read) && (r_strobes != 2'd3)) begin
            r_strobes <= r_strobes + 2'd1;
        end
    end

    a_one_strobe_per_xfer: assert property (@(posedge clk) disable iff (!rst_n)
        pready |-> (r_strobes == {1'b0, hit}));

    a_pready_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        pready |=> !pready);

    a_no_strobe_on_miss: assert property (@(posedge clk) disable iff (!rst_n)
        ((state == ISSUE) && !hit) |-> !(write || read));

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(write && read));

endmodule

bind shape_processor_apb_bridge shape_processor_apb_bridge_props u_props (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (r_state),
    .hit    (r_hit),
    .write  (write),
    .read   (read),
    .pready (w_pready)
);

// File: rtl/shape_processor_apb_bridge.sv
// -----------------------------------------------------------------------------
// shape_processor_apb_bridge
// APB3 slave that turns each APB transfer into one single-cycle write or read
// strobe towards shape_processor and returns its error/read data.
//   clk          : clock, all logic on posedge
//   rst_n        : asynchronous active-low reset
//   apb          : APB3 slave port (psel/penable/pwrite/paddr/pwdata in,
//                  prdata/pready/pslverr out)
//   write        : write strobe to processor
//   write_data   : write data to processor, holds between strobes
//   read         : read strobe to processor
//   read_data    : processor read data, valid the cycle after read
//   error        : processor error, valid the cycle after a strobe
//   protocol_err : sticky, set when the master drops psel mid-transfer
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an APB setup phase
// ISSUE   | drive the write/read strobe (only on an address hit)
// CAPTURE | sample processor error/read data, load the wait counter
// WAIT    | count down inserted wait states
// RESP    | drive pready/pslverr/prdata for one cycle
// -----------------------------------------------------------------------------
module shape_processor_apb_bridge
    import shape_processor_apb_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(CTRL_SFR_ADDR),
    parameter int                    WAIT_STATES = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    shape_processor_apb_bridge_if.slave apb,
    output logic                        write,
    output logic [31:0]                 write_data,
    output logic                        read,
    input  logic [31:0]                 read_data,
    input  logic                        error,
    output logic                        protocol_err
);

    localparam logic [WAIT_CNT_WIDTH-1:0] LP_WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
    localparam bit                        LP_HAS_WAIT  = (WAIT_STATES > 0);

    bridge_state_e             r_state;
    bridge_state_e             w_next;
    logic                      r_pwrite;
    logic                      r_hit;
    logic [31:0]               r_write_data;
    logic                      r_err;
    logic [31:0]               r_rdata;
    logic [WAIT_CNT_WIDTH-1:0] r_cnt;
    logic                      r_protocol_err;

    logic                      w_setup;
    logic                      w_abort;
    logic                      w_resp;
    logic                      w_pready;

    assign w_setup = apb.psel && !apb.penable;
    // Any loss of psel once a transfer has started abandons it.
    assign w_abort = (r_state != IDLE) && !apb.psel;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_setup) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = LP_HAS_WAIT ? WAIT : RESP;
            WAIT:    if (r_cnt <= 1) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort wins over the normal sequence; an ISSUE strobe is already out.
        if (w_abort) w_next = IDLE;
    end

    // Transfer capture registers, wait counter and sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwrite       <= 1'b0;
            r_hit          <= 1'b0;
            r_write_data   <= 32'h0;
            r_err          <= 1'b0;
            r_rdata        <= 32'h0;
            r_cnt          <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_pwrite <= apb.pwrite;
                        r_hit    <= (apb.paddr == CTRL_ADDR);
                        // Only a hit write moves write_data, so it changes exactly
                        // when the write strobe rises and holds otherwise.
                        if ((apb.paddr == CTRL_ADDR) && apb.pwrite) begin
                            r_write_data <= apb.pwdata;
                        end
                    end
                end
                CAPTURE: begin
                    r_err   <= !r_hit || error;
                    r_rdata <= (r_hit && !r_pwrite && !error) ? read_data : 32'h0;
                    r_cnt   <= LP_WAIT_LOAD;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
            if (w_abort) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        write    = (r_state == ISSUE) && r_hit && r_pwrite;
        read     = (r_state == ISSUE) && r_hit && !r_pwrite;
        w_resp   = (r_state == RESP) && apb.psel;
        w_pready = w_resp;
    end

    assign apb.pready   = w_pready;
    assign apb.pslverr  = w_resp ? r_err : 1'b0;
    assign apb.prdata   = w_resp ? r_rdata : 32'h0;
    assign write_data   = r_write_data;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_shape_processor_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_shape_processor_apb_bridge
// Two bridges (0 and 3 wait states) share one APB master. Each has its own
// processor model. Expected strobes and responses are queued by the master;
// a negedge monitor pops and compares whatever each bridge presents.
// -----------------------------------------------------------------------------
module tb_shape_processor_apb_bridge;
    import shape_processor_apb_bridge_pkg::*;

    typedef struct {
        bit          is_write;
        logic [31:0] wd;
        logic [31:0] rdata;
        bit          err;
        int          t;
    } xact_t;

    localparam int WAITS [2] = '{0, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_psel    = 1'b0;
    logic        m_penable = 1'b0;
    logic        m_pwrite  = 1'b0;
    logic [7:0]  m_paddr   = 8'h00;
    logic [31:0] m_pwdata  = 32'h0;

    shape_processor_apb_bridge_if #(.ADDR_WIDTH(8)) apb0 ();
    shape_processor_apb_bridge_if #(.ADDR_WIDTH(8)) apb3 ();

    assign apb0.psel = m_psel;  assign apb0.penable = m_penable; assign apb0.pwrite = m_pwrite;
    assign apb0.paddr = m_paddr; assign apb0.pwdata = m_pwdata;
    assign apb3.psel = m_psel;  assign apb3.penable = m_penable; assign apb3.pwrite = m_pwrite;
    assign apb3.paddr = m_paddr; assign apb3.pwdata = m_pwdata;

    logic        wr   [2];
    logic        rd   [2];
    logic [31:0] wd   [2];
    logic [31:0] prd  [2];
    logic        perr [2];
    logic        pe   [2];
    logic [31:0] psfr [2] = '{32'h0, 32'h0};

    shape_processor_apb_bridge #(.ADDR_WIDTH(8), .CTRL_ADDR(8'h00), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .apb(apb0.slave),
        .write(wr[0]), .write_data(wd[0]), .read(rd[0]),
        .read_data(prd[0]), .error(perr[0]), .protocol_err(pe[0]));

    shape_processor_apb_bridge #(.ADDR_WIDTH(8), .CTRL_ADDR(8'h00), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .apb(apb3.slave),
        .write(wr[1]), .write_data(wd[1]), .read(rd[1]),
        .read_data(prd[1]), .error(perr[1]), .protocol_err(pe[1]));

    // Processor stand-in: writes with bit31 set are illegal shapes and rejected;
    // reads error when the stored CTRL has bit30 set. Outside the response cycle
    // read_data/error carry noise the bridge must not use.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prd[i]  <= rd[i] ? psfr[i] : $urandom();
            perr[i] <= wr[i] ? wd[i][31] : (rd[i] ? psfr[i][30] : 1'($urandom_range(0, 1)));
            if (wr[i] && !wd[i][31]) psfr[i] <= wd[i];
        end
    end

    int          n_chk  = 0;
    int          n_fail = 0;
    xact_t       sq [2][$];
    xact_t       rq [2][$];
    logic [31:0] exp_wd [2] = '{32'h0, 32'h0};
    logic [31:0] m_sfr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Spec cycle index: the interval after edge k is cycle k+1.
    task automatic mon(input int id, input logic pr, input logic se, input logic [31:0] pd,
                       input logic w, input logic r, input logic [31:0] wdat);
        xact_t e;
        int    now = cyc + 1;
        if (w && r) fail_now($sformatf("dut%0d both strobes high", WAITS[id]));
        if (w || r) begin
            if (sq[id].size() == 0) begin
                fail_now($sformatf("dut%0d unexpected strobe", WAITS[id]));
            end else begin
                e = sq[id].pop_front();
                chk($sformatf("dut%0d strobe_is_write", WAITS[id]), 32'(w), 32'(e.is_write));
                chk($sformatf("dut%0d strobe_cycle", WAITS[id]), now, e.t + 1);
                if (w) begin
                    chk($sformatf("dut%0d write_data", WAITS[id]), wdat, e.wd);
                    exp_wd[id] = e.wd;
                end
            end
        end else begin
            chk($sformatf("dut%0d write_data_hold", WAITS[id]), wdat, exp_wd[id]);
        end
        if (pr) begin
            if (rq[id].size() == 0) begin
                fail_now($sformatf("dut%0d unexpected pready", WAITS[id]));
            end else begin
                e = rq[id].pop_front();
                chk($sformatf("dut%0d prdata", WAITS[id]), pd, e.rdata);
                chk($sformatf("dut%0d pslverr", WAITS[id]), 32'(se), 32'(e.err));
                chk($sformatf("dut%0d pready_cycle", WAITS[id]), now, e.t + 3 + WAITS[id]);
            end
        end else begin
            chk($sformatf("dut%0d prdata_idle", WAITS[id]), pd, 32'h0);
            chk($sformatf("dut%0d pslverr_idle", WAITS[id]), 32'(se), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, apb0.pready, apb0.pslverr, apb0.prdata, wr[0], rd[0], wd[0]);
            mon(1, apb3.pready, apb3.pslverr, apb3.prdata, wr[1], rd[1], wd[1]);
        end
    end

    // Reference model: what the processor holds and what each transfer returns.
    task automatic push(input bit wr_, input logic [7:0] addr, input logic [31:0] data,
                        input bit resp, input int t);
        xact_t e;
        bit    hit = (addr == 8'h00);
        e.is_write = wr_;
        e.wd       = data;
        e.t        = t;
        if (!hit) begin
            e.err = 1'b1;  e.rdata = 32'h0;
        end else if (wr_) begin
            e.err = data[31]; e.rdata = 32'h0;
            if (!data[31]) m_sfr = data;
        end else begin
            e.err   = m_sfr[30];
            e.rdata = m_sfr[30] ? 32'h0 : m_sfr;
        end
        for (int i = 0; i < 2; i++) begin
            if (hit)  sq[i].push_back(e);
            if (resp) rq[i].push_back(e);
        end
    endtask

    task automatic setup(input bit wr_, input logic [7:0] addr, input logic [31:0] data, output int t);
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr_; m_paddr = addr; m_pwdata = data;
        t = cyc + 1;
    endtask

    // abort = 1 drops psel during CAPTURE.
    task automatic xfer(input bit wr_, input logic [7:0] addr, input logic [31:0] data, input bit abort);
        int t;
        int n;
        setup(wr_, addr, data, t);
        push(wr_, addr, data, !abort, t);
        @(posedge clk); #1;
        m_penable = 1'b1;
        if (abort) begin
            @(posedge clk); #1;
            m_psel = 1'b0; m_penable = 1'b0;
            repeat (8) @(posedge clk);
        end else begin
            for (n = 0; n < 40; n++) begin
                @(negedge clk);
                if (apb3.pready) break;
            end
            if (n == 40) fail_now("pready timeout");
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dut0 pready"},       32'(apb0.pready),  32'h0);
        chk({tag, " dut0 pslverr"},      32'(apb0.pslverr), 32'h0);
        chk({tag, " dut0 prdata"},       apb0.prdata,       32'h0);
        chk({tag, " dut0 strobes"},      32'({wr[0], rd[0]}), 32'h0);
        chk({tag, " dut0 write_data"},   wd[0],             32'h0);
        chk({tag, " dut0 protocol_err"}, 32'(pe[0]),        32'h0);
        chk({tag, " dut3 pready"},       32'(apb3.pready),  32'h0);
        chk({tag, " dut3 pslverr"},      32'(apb3.pslverr), 32'h0);
        chk({tag, " dut3 prdata"},       apb3.prdata,       32'h0);
        chk({tag, " dut3 strobes"},      32'({wr[1], rd[1]}), 32'h0);
        chk({tag, " dut3 write_data"},   wd[1],             32'h0);
        chk({tag, " dut3 protocol_err"}, 32'(pe[1]),        32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int          t;
        bit          rw;
        logic [7:0]  a;
        logic [31:0] d;

        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        xfer(1'b1, 8'h00, 32'h0000_0102, 1'b0);   // legal write
        xfer(1'b0, 8'h00, 32'h0, 1'b0);           // read back 0x102
        xfer(1'b1, 8'h00, 32'h8000_0005, 1'b0);   // illegal shape, rejected
        xfer(1'b0, 8'h00, 32'h0, 1'b0);           // still 0x102
        idle(1);
        xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0);   // decode miss write
        xfer(1'b0, 8'h10, 32'h0, 1'b0);           // decode miss read
        xfer(1'b1, 8'h00, 32'h0000_0033, 1'b0);   // back-to-back write then read
        xfer(1'b0, 8'h00, 32'h0, 1'b0);
        xfer(1'b1, 8'h00, 32'h4000_0001, 1'b0);   // legal, but reads will error
        xfer(1'b0, 8'h00, 32'h0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            d  = $urandom();
            xfer(rw, a, d, 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end

        idle(1);
        chk("dut0 protocol_err before abort", 32'(pe[0]), 32'h0);
        chk("dut3 protocol_err before abort", 32'(pe[1]), 32'h0);
        xfer(1'b0, 8'h00, 32'h0, 1'b1);           // abandon during CAPTURE
        chk("dut0 protocol_err after abort", 32'(pe[0]), 32'h1);
        chk("dut3 protocol_err after abort", 32'(pe[1]), 32'h1);
        xfer(1'b1, 8'h00, 32'h0000_0077, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 1'b0);
        idle(2);
        chk("dut0 protocol_err sticky", 32'(pe[0]), 32'h1);
        chk("dut3 protocol_err sticky", 32'(pe[1]), 32'h1);

        // Reset while dut3 sits in WAIT (dut0 is in RESP that cycle).
        setup(1'b0, 8'h00, 32'h0, t);
        push(1'b0, 8'h00, 32'h0, 1'b0, t);
        @(posedge clk); #1 m_penable = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0;
        #1 chk_all_zero("mid-wait reset");
        exp_wd[0] = 32'h0;
        exp_wd[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        xfer(1'b0, 8'h00, 32'h0, 1'b0);
        xfer(1'b1, 8'h00, 32'h0000_0204, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 1'b0);
        idle(4);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d strobe queue drained", WAITS[i]), sq[i].size(), 32'h0);
            chk($sformatf("dut%0d response queue drained", WAITS[i]), rq[i].size(), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
